// File: rtl/inccomp_pkg.sv
// inccomp_pkg: shared lead-state enum, select-width helper and reset constants.
package inccomp_pkg;
  typedef enum logic [1:0] {TIE = 2'd0, LEAD_A = 2'd1, LEAD_B = 2'd2} lead_t;
  localparam logic RST_EQ = 1'b1;
  localparam lead_t RST_LEAD = TIE;
  function automatic int sel_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/inccomp_multi_if.sv
// inccomp_multi_if: strobe/select inputs and compare/status outputs of inccomp_multi.
interface inccomp_multi_if import inccomp_pkg::*; #(parameter int W = 8, parameter int NCH = 2);
  localparam int SW = sel_w(NCH);
  logic clr;
  logic [NCH-1:0] inc;
  logic [SW-1:0] sel_a;
  logic [SW-1:0] sel_b;
  logic [W-1:0] C;
  logic a_gt_b;
  logic a_lt_b;
  logic a_eq_b;
  logic lead_chg;
  logic [NCH-1:0] ovf;
  modport master (output clr, inc, sel_a, sel_b, input C, a_gt_b, a_lt_b, a_eq_b, lead_chg, ovf);
  modport slave (input clr, inc, sel_a, sel_b, output C, a_gt_b, a_lt_b, a_eq_b, lead_chg, ovf);
endinterface

// File: rtl/inccomp_ch.sv
// inccomp_ch: one event counter with sticky ovf; INCCOMP_SAT_EN selects saturate instead of wrap.
module inccomp_ch #(
  parameter int W = 8,
  parameter int STEP = 1
) (
  input  logic ck,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic [W-1:0] cnt,
  output logic ovf
);
  logic [W-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic [W:0] sum;
  always_comb begin
    sum = {1'b0, cnt_q} + (W+1)'(STEP);
`ifdef INCCOMP_SAT_EN
    cnt_d = clr ? '0 : !inc ? cnt_q : sum[W] ? '1 : sum[W-1:0];
`else
    cnt_d = clr ? '0 : inc ? sum[W-1:0] : cnt_q;
`endif
    ovf_d = !clr && (ovf_q || (inc && sum[W]));
  end
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
  assign cnt = cnt_q;
  assign ovf = ovf_q;
endmodule

// File: rtl/inccomp_multi.sv
// inccomp_multi: NCH event counters, two selected channels compared with registered |A-B|, flags and lead FSM.
// Build with INCCOMP_SAT_EN defined for saturating counters.
module inccomp_multi import inccomp_pkg::*; #(
  parameter int W = 8,
  parameter int NCH = 2,
  parameter int STEP = 1
) (
  input  logic ck,
  input  logic rst,
  inccomp_multi_if.slave bus
);
  localparam int SW = sel_w(NCH);
  logic [W-1:0] cnt [NCH];
  logic [NCH-1:0] ovf;
  logic [SW-1:0] sa, sb, sa_q, sb_q;
  logic [W-1:0] a, b, c_q, c_d;
  logic [W:0] diff;
  logic gt_q, lt_q, eq_q, gt_d, lt_d, eq_d, lc_q, lc_d, hold;
  lead_t state_q, state_d, mem_q, mem_d, nxt, ldr;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    inccomp_ch #(.W(W), .STEP(STEP)) u_ch (
      .ck(ck), .rst(rst), .clr(bus.clr), .inc(bus.inc[i]), .cnt(cnt[i]), .ovf(ovf[i])
    );
  end
  always_comb begin
    sa = (32'(bus.sel_a) < NCH) ? bus.sel_a : '0;
    sb = (32'(bus.sel_b) < NCH) ? bus.sel_b : '0;
    a = cnt[sa];
    b = cnt[sb];
    diff = {1'b0, a} - {1'b0, b};
    lt_d = !bus.clr && diff[W];
    eq_d = bus.clr || diff == '0;
    gt_d = !lt_d && !eq_d;
    c_d = bus.clr ? '0 : diff[W] ? b - a : a - b;
    // Leader survives a TIE in mem_q; any select change or equal selects wipe it.
    hold = bus.clr || sa != sa_q || sb != sb_q || sa == sb;
    nxt = gt_q ? LEAD_A : lt_q ? LEAD_B : TIE;
    ldr = (state_q != TIE) ? state_q : mem_q;
    state_d = hold ? TIE : nxt;
    mem_d = hold ? TIE : (nxt != TIE) ? nxt : ldr;
    lc_d = !hold && nxt != TIE && ldr != TIE && nxt != ldr;
  end
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      c_q <= '0;
      gt_q <= 1'b0;
      lt_q <= 1'b0;
      eq_q <= RST_EQ;
      lc_q <= 1'b0;
      state_q <= RST_LEAD;
      mem_q <= RST_LEAD;
      sa_q <= '0;
      sb_q <= '0;
    end else begin
      c_q <= c_d;
      gt_q <= gt_d;
      lt_q <= lt_d;
      eq_q <= eq_d;
      lc_q <= lc_d;
      state_q <= state_d;
      mem_q <= mem_d;
      sa_q <= sa;
      sb_q <= sb;
    end
  end
  assign bus.C = c_q;
  assign bus.a_gt_b = gt_q;
  assign bus.a_lt_b = lt_q;
  assign bus.a_eq_b = eq_q;
  assign bus.lead_chg = lc_q;
  assign bus.ovf = ovf;
endmodule

// File: tb/tb_inccomp_multi.sv
// tb_inccomp_multi: directed-vector bench for inccomp_multi (W=8, NCH=4, STEP=1).
module tb_inccomp_multi;
  localparam int W = 8;
  localparam int NCH = 4;
  localparam logic [2:0] EQ = 3'b001, LT = 3'b010, GT = 3'b100;
  logic ck = 1'b0;
  logic rst;
  int errs = 0;
  int checks = 0;
  inccomp_multi_if #(.W(W), .NCH(NCH)) bus ();
  inccomp_multi #(.W(W), .NCH(NCH), .STEP(1)) dut (.ck(ck), .rst(rst), .bus(bus));
  always #5 ck = ~ck;
  logic [3:0] v_inc [16] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b0011, 4'b0011,
                             4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
  int v_c [16] = '{0, 1, 2, 3, 4, 4, 4, 4, 4, 3, 2, 1, 0, 1, 2, 2};
  logic [2:0] v_f [16] = '{EQ, GT, GT, GT, GT, GT, GT, GT, GT, GT, GT, GT, EQ, LT, LT, LT};
  logic v_lc [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge ck);
    #1;
  endtask
  task automatic outs(input string tag, input int c, input logic [2:0] f, input logic lc);
    chk({tag, ".C"}, 32'(bus.C), c);
    chk({tag, ".flags"}, 32'({bus.a_gt_b, bus.a_lt_b, bus.a_eq_b}), 32'(f));
    chk({tag, ".lead_chg"}, 32'(bus.lead_chg), 32'(lc));
  endtask
  initial begin
    rst = 1'b0;
    bus.clr = 1'b0;
    bus.inc = 4'b0001;
    bus.sel_a = 2'd0;
    bus.sel_b = 2'd1;
    #12;
    outs("reset", 0, EQ, 1'b0);
    chk("reset.ovf", 32'(bus.ovf), 0);
    rst = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus.inc = v_inc[k];
      step();
      outs($sformatf("vec%0d", k), v_c[k], v_f[k], v_lc[k]);
    end
    // counters now c0=8 c1=10 c2=0 c3=0, leader B
    bus.sel_b = 2'd2;
    step();
    outs("selb_chg", 8, GT, 1'b0);
    step();
    outs("selb_hold", 8, GT, 1'b0);
    bus.sel_a = 2'd2;
    bus.sel_b = 2'd1;
    step();
    outs("sela_chg", 10, LT, 1'b0);
    step();
    outs("sela_hold", 10, LT, 1'b0);
    bus.sel_a = 2'd1;
    step();
    outs("same_sel", 0, EQ, 1'b0);
    bus.sel_a = 2'd0;
    bus.inc = 4'b0001;
    repeat (247) step();
    chk("pre_wrap.ovf", 32'(bus.ovf), 0);
    step();
    chk("wrap.ovf", 32'(bus.ovf), 1);
    chk("wrap.C", 32'(bus.C), 245);
    bus.inc = 4'b0000;
    step();
`ifdef INCCOMP_SAT_EN
    chk("post_wrap.C", 32'(bus.C), 245);
    chk("post_wrap.flags", 32'({bus.a_gt_b, bus.a_lt_b, bus.a_eq_b}), 32'(GT));
`else
    chk("post_wrap.C", 32'(bus.C), 10);
    chk("post_wrap.flags", 32'({bus.a_gt_b, bus.a_lt_b, bus.a_eq_b}), 32'(LT));
`endif
    chk("post_wrap.ovf", 32'(bus.ovf), 1);
    bus.clr = 1'b1;
    bus.inc = 4'b0001;
    step();
    outs("clr", 0, EQ, 1'b0);
    chk("clr.ovf", 32'(bus.ovf), 0);
    bus.clr = 1'b0;
    bus.inc = 4'b0000;
    step();
    outs("after_clr", 0, EQ, 1'b0);
    bus.inc = 4'b0001;
    step();
    step();
    outs("restart", 1, GT, 1'b0);
    #1 rst = 1'b0;
    #1;
    outs("async_rst", 0, EQ, 1'b0);
    chk("async_rst.ovf", 32'(bus.ovf), 0);
    rst = 1'b1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
